alarm_clock_multi: RTL

// Time-of-day clock (sec/min/hrs/day-of-week) with N independent alarms, per-alarm
// day-of-week enable masks, snooze and ring timeout. Successor to the single-alarm

---
 rtl/alarm_clock_multi_if.sv | 27 ++
 rtl/alarm_clock_multi.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock_multi_if.sv
// Pin bundle for alarm_clock_multi.
//   master : pushbutton/controller side (drives buttons, reads time and display)
//   slave  : the clock itself
// Inputs : Timeset, Alarmset, AlarmSel, Minadv, Hrsadv, Dayadv, Alarmon, Snooze
// Outputs: TSec, TMin, THrs, TDay, DispMin, DispHrs, DispMask, Buzz, AlarmId
interface alarm_clock_multi_if #(
  parameter int N_ALARMS = 4,
  parameter int AW       = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
);
  logic          Timeset, Alarmset;
  logic [AW-1:0] AlarmSel;
  logic          Minadv, Hrsadv, Dayadv, Alarmon, Snooze;
  logic [6:0]    TSec, TMin, THrs;
  logic [2:0]    TDay;
  logic [6:0]    DispMin, DispHrs, DispMask;
  logic          Buzz;
  logic [AW-1:0] AlarmId;

  modport master (
    output Timeset, Alarmset, AlarmSel, Minadv, Hrsadv, Dayadv, Alarmon, Snooze,
    input  TSec, TMin, THrs, TDay, DispMin, DispHrs, DispMask, Buzz, AlarmId
  );
  modport slave (
    input  Timeset, Alarmset, AlarmSel, Minadv, Hrsadv, Dayadv, Alarmon, Snooze,
    output TSec, TMin, THrs, TDay, DispMin, DispHrs, DispMask, Buzz, AlarmId
  );
endinterface

// File: rtl/alarm_clock_multi.sv
// Time-of-day clock with N_ALARMS independent alarm slots, per-slot day-of-week
// masks, snooze with a per-event limit and a ring timeout.
//   Pulse : 1 Hz clock          Reset : synchronous, active high
//   bus   : alarm_clock_multi_if.slave (buttons in; time, display, Buzz, AlarmId out)

// One alarm slot: stored time, day mask, and its match term.
module alarm_clock_multi_slot #(
  parameter logic [6:0] RESET_MASK = 7'b0011111
) (
  input  logic       Pulse,
  input  logic       Reset,
  input  logic       edit,
  input  logic       minadv,
  input  logic       hrsadv,
  input  logic       dayadv,
  input  logic       armed,
  input  logic [6:0] tmin,
  input  logic [6:0] thrs,
  input  logic [2:0] tday,
  output logic [6:0] amin,
  output logic [6:0] ahrs,
  output logic [6:0] mask,
  output logic       hit
);
  always_ff @(posedge Pulse) begin
    if (Reset) begin
      amin <= '0;
      ahrs <= '0;
      mask <= RESET_MASK;
    end else if (edit) begin
      if (minadv) amin <= (amin == 7'd59) ? '0 : amin + 7'd1;
      if (hrsadv) ahrs <= (ahrs == 7'd23) ? '0 : ahrs + 7'd1;
      // toggles the bit for the day currently shown on the clock
      if (dayadv) mask[tday] <= ~mask[tday];
    end
  end

  assign hit = armed & (amin == tmin) & (ahrs == thrs) & mask[tday];
endmodule

module alarm_clock_multi #(
  parameter int         N_ALARMS   = 4,
  parameter int         SNOOZE_SEC = 300,
  parameter int         RING_SEC   = 60,
  parameter int         MAX_SNOOZE = 3,
  parameter logic [6:0] RESET_MASK = 7'b0011111
) (
  input logic                Pulse,
  input logic                Reset,
  alarm_clock_multi_if.slave bus
);
  localparam int AW   = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
  localparam int TMAX = (SNOOZE_SEC > RING_SEC) ? SNOOZE_SEC : RING_SEC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int CW   = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam logic [TW-1:0] RING_T = TW'(RING_SEC - 1);
  localparam logic [TW-1:0] SNZ_T  = TW'(SNOOZE_SEC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RING = 2'd1;
  localparam logic [1:0] S_SNZ  = 2'd2;

  logic [6:0] tsec, tmin, thrs;
  logic [2:0] tday;
  logic [N_ALARMS-1:0][6:0] amin, ahrs, mask;
  logic [N_ALARMS-1:0]      hits;
  logic                     armed, editing, any_hit;
  logic [AW-1:0]            hit_id;

  // ---------------- time of day ----------------
  logic sec_wrap, min_wrap, hrs_wrap;
  assign sec_wrap = (tsec == 7'd59);
  assign min_wrap = sec_wrap & (tmin == 7'd59);
  assign hrs_wrap = min_wrap & (thrs == 7'd23);

  always_ff @(posedge Pulse) begin
    if (Reset) begin
      tsec <= '0; tmin <= '0; thrs <= '0; tday <= '0;
    end else if (bus.Timeset) begin
      // buttons step their own field only; no carry between fields
      if (bus.Minadv) tmin <= (tmin == 7'd59) ? '0 : tmin + 7'd1;
      if (bus.Hrsadv) thrs <= (thrs == 7'd23) ? '0 : thrs + 7'd1;
      if (bus.Dayadv) tday <= (tday == 3'd6)  ? '0 : tday + 3'd1;
    end else begin
      tsec <= sec_wrap ? '0 : tsec + 7'd1;
      if (sec_wrap) tmin <= min_wrap ? '0 : tmin + 7'd1;
      if (min_wrap) thrs <= hrs_wrap ? '0 : thrs + 7'd1;
      if (hrs_wrap) tday <= (tday == 3'd6) ? '0 : tday + 3'd1;
    end
  end

  // ---------------- alarm slots ----------------
  assign armed   = bus.Alarmon & ~bus.Timeset & ~bus.Alarmset & (tsec == 7'd0);
  assign editing = bus.Alarmset & ~bus.Timeset;

  for (genvar i = 0; i < N_ALARMS; i++) begin : g_slot
    alarm_clock_multi_slot #(.RESET_MASK(RESET_MASK)) u_slot (
      .Pulse (Pulse),
      .Reset (Reset),
      .edit  (editing && (int'(bus.AlarmSel) == i)),
      .minadv(bus.Minadv),
      .hrsadv(bus.Hrsadv),
      .dayadv(bus.Dayadv),
      .armed (armed),
      .tmin  (tmin),
      .thrs  (thrs),
      .tday  (tday),
      .amin  (amin[i]),
      .ahrs  (ahrs[i]),
      .mask  (mask[i]),
      .hit   (hits[i])
    );
  end

  // lowest-numbered matching slot wins
  always_comb begin
    any_hit = 1'b0;
    hit_id  = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (hits[i]) begin
        any_hit = 1'b1;
        hit_id  = AW'(i);
      end
    end
  end

  // ---------------- display mux ----------------
  // out-of-range selects read as zero
  logic [6:0] sel_min, sel_hrs, sel_mask;
  always_comb begin
    sel_min = '0; sel_hrs = '0; sel_mask = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      if (int'(bus.AlarmSel) == i) begin
        sel_min  = amin[i];
        sel_hrs  = ahrs[i];
        sel_mask = mask[i];
      end
    end
  end

  // ---------------- ring / snooze FSM ----------------
  logic [1:0]    state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] aid, aid_nxt;
  logic          buzz;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    cnt_nxt   = cnt;
    aid_nxt   = aid;
    case (state)
      S_IDLE: if (any_hit) begin
        state_nxt = S_RING; timer_nxt = RING_T; cnt_nxt = '0; aid_nxt = hit_id;
      end
      S_RING: begin
        // new matches are ignored while ringing
        if (!bus.Alarmon)                               state_nxt = S_IDLE;
        else if (bus.Snooze && int'(cnt) < MAX_SNOOZE) begin
          state_nxt = S_SNZ; timer_nxt = SNZ_T; cnt_nxt = cnt + CW'(1);
        end
        else if (timer == '0)                           state_nxt = S_IDLE;
        else                                            timer_nxt = timer - TW'(1);
      end
      S_SNZ: begin
        if (!bus.Alarmon) state_nxt = S_IDLE;
        else if (any_hit) begin
          state_nxt = S_RING; timer_nxt = RING_T; cnt_nxt = '0; aid_nxt = hit_id;
        end
        else if (timer == '0) begin
          // snooze expiry keeps the snooze count of the current event
          state_nxt = S_RING; timer_nxt = RING_T;
        end
        else timer_nxt = timer - TW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Pulse) begin
    if (Reset) begin
      state <= S_IDLE; timer <= '0; cnt <= '0; aid <= '0; buzz <= 1'b0;
    end else begin
      state <= state_nxt; timer <= timer_nxt; cnt <= cnt_nxt; aid <= aid_nxt;
      buzz  <= (state_nxt == S_RING);
    end
  end

  assign bus.TSec     = tsec;
  assign bus.TMin     = tmin;
  assign bus.THrs     = thrs;
  assign bus.TDay     = tday;
  assign bus.DispMin  = bus.Alarmset ? sel_min : tmin;
  assign bus.DispHrs  = bus.Alarmset ? sel_hrs : thrs;
  assign bus.DispMask = sel_mask;
  assign bus.Buzz     = buzz;
  assign bus.AlarmId  = aid;
endmodule
